unlock_ctrl: RTL and testbench

UNLOCK_CTRL -- requirements
Module: unlock_ctrl

---
 rtl/unlock_ctrl_pkg.sv | 26 ++
 rtl/unlock_timer.sv | 28 ++
 rtl/unlock_ctrl.sv | 164 ++++++++++++++++
 tb/tb_unlock_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/unlock_ctrl_pkg.sv
// Shared types and constants for the keypad unlock controller.
package unlock_ctrl_pkg;

  localparam int DIGIT_W = 2;

  localparam logic [1:0] RES_IDLE  = 2'b00;
  localparam logic [1:0] RES_ENTRY = 2'b01;
  localparam logic [1:0] RES_PASS  = 2'b10;
  localparam logic [1:0] RES_FAIL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_PASS,
    ST_FAIL,
    ST_LOCKOUT
  } state_t;

  function automatic logic [DIGIT_W-1:0] key_digit(input logic k2, input logic k3);
    if (k3)      return 2'd3;
    else if (k2) return 2'd2;
    else         return 2'd1;
  endfunction

endpackage

// File: rtl/unlock_timer.sv
// Loadable down-counter; done is high while running with the count at zero.
module unlock_timer #(
  parameter int CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic done
);

  localparam int W = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= LOAD_VAL;
    else if (run && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  assign done = run && (cnt == '0);

endmodule

// File: rtl/unlock_ctrl.sv
// Keypad code checker with consecutive-failure lockout and inactivity timeout.
//   state      | meaning
//   ST_IDLE    | waiting for the first digit
//   ST_ENTRY   | collecting digits until ok
//   ST_CHECK   | one-cycle compare of entry against CODE
//   ST_PASS    | code accepted, holding result until next digit
//   ST_FAIL    | code rejected; locks out when fail limit is reached
//   ST_LOCKOUT | all inputs ignored for LOCK_CYC cycles
module unlock_ctrl
  import unlock_ctrl_pkg::*;
#(
  parameter int          CODE_LEN = 4,
  parameter logic [13:0] CODE     = 14'b01_10_11_01_00_00_00,
  parameter int          MAX_FAIL = 3,
  parameter int          LOCK_CYC = 250_000_000,
  parameter int          IDLE_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key1_p,
  input  logic       key2_p,
  input  logic       key3_p,
  input  logic       ok_p,
  output logic [1:0] result,
  output logic       result_vld,
  output logic [2:0] digit_cnt,
  output logic       locked
);

  localparam int EW = DIGIT_W * CODE_LEN;
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [EW-1:0] CODE_REF = CODE[13 -: EW];
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
  localparam logic [2:0]    LEN      = 3'(CODE_LEN);

  state_t               state;
  logic [EW-1:0]        entry;
  logic                 overflow;
  logic [FW-1:0]        fail_cnt;

  logic                 single, dig_p, ok_acc, lock_now, code_match;
  logic [DIGIT_W-1:0]   digit;
  logic [2:0]           cnt_inc;
  logic                 idle_load, idle_run, idle_done;
  logic                 lock_run, lock_done;

  // Simultaneous pulses on several inputs are treated as noise and dropped.
  assign single     = $onehot({key1_p, key2_p, key3_p, ok_p});
  assign dig_p      = single && !ok_p;
  assign ok_acc     = single && ok_p;
  assign digit      = key_digit(key2_p, key3_p);
  assign lock_now   = (state == ST_FAIL) && (fail_cnt == FAIL_MAX);
  assign cnt_inc    = (digit_cnt == 3'd7) ? 3'd7 : digit_cnt + 3'd1;
  assign code_match = (digit_cnt == LEN) && !overflow && (entry == CODE_REF);

  assign idle_run  = (state == ST_ENTRY) || (state == ST_PASS) || (state == ST_FAIL);
  assign idle_load = (dig_p && !lock_now && (state != ST_CHECK) && (state != ST_LOCKOUT))
                     || (ok_acc && (state == ST_ENTRY));
  assign lock_run  = (state == ST_LOCKOUT);

  unlock_timer #(.CYC(IDLE_CYC)) u_idle_tmr (
    .clk  (clk),
    .rst  (rst),
    .load (idle_load),
    .run  (idle_run),
    .done (idle_done)
  );

  unlock_timer #(.CYC(LOCK_CYC)) u_lock_tmr (
    .clk  (clk),
    .rst  (rst),
    .load (lock_now),
    .run  (lock_run),
    .done (lock_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      entry      <= '0;
      overflow   <= 1'b0;
      fail_cnt   <= '0;
      result     <= RES_IDLE;
      result_vld <= 1'b0;
      digit_cnt  <= 3'd0;
      locked     <= 1'b0;
    end else begin
      result_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dig_p) begin
            entry     <= EW'(digit);
            digit_cnt <= 3'd1;
            overflow  <= 1'b0;
            result    <= RES_ENTRY;
            state     <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (dig_p) begin
            digit_cnt <= cnt_inc;
            if (digit_cnt < LEN)
              entry <= (entry << DIGIT_W) | EW'(digit);
            else
              overflow <= 1'b1;
          end else if (ok_acc) begin
            state <= ST_CHECK;
          end else if (idle_done) begin
            entry     <= '0;
            digit_cnt <= 3'd0;
            overflow  <= 1'b0;
            result    <= RES_IDLE;
            state     <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          result_vld <= 1'b1;
          if (code_match) begin
            fail_cnt <= '0;
            result   <= RES_PASS;
            state    <= ST_PASS;
          end else begin
            if (fail_cnt != FAIL_MAX)
              fail_cnt <= fail_cnt + FW'(1);
            result <= RES_FAIL;
            state  <= ST_FAIL;
          end
        end
        ST_PASS, ST_FAIL: begin
          if (lock_now) begin
            locked <= 1'b1;
            result <= RES_FAIL;
            state  <= ST_LOCKOUT;
          end else if (dig_p) begin
            entry     <= EW'(digit);
            digit_cnt <= 3'd1;
            overflow  <= 1'b0;
            result    <= RES_ENTRY;
            state     <= ST_ENTRY;
          end else if (idle_done) begin
            entry     <= '0;
            digit_cnt <= 3'd0;
            overflow  <= 1'b0;
            result    <= RES_IDLE;
            state     <= ST_IDLE;
          end
        end
        ST_LOCKOUT: begin
          if (lock_done) begin
            locked    <= 1'b0;
            fail_cnt  <= '0;
            entry     <= '0;
            digit_cnt <= 3'd0;
            overflow  <= 1'b0;
            result    <= RES_IDLE;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unlock_ctrl.sv
// Directed bench for unlock_ctrl with short lockout/inactivity timers.
module tb_unlock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key1_p = 1'b0, key2_p = 1'b0, key3_p = 1'b0, ok_p = 1'b0;
  logic [1:0] result;
  logic       result_vld;
  logic [2:0] digit_cnt;
  logic       locked;

  int total = 0;
  int bad   = 0;

  unlock_ctrl #(
    .CODE_LEN (4),
    .CODE     (14'b01_10_11_01_00_00_00),
    .MAX_FAIL (3),
    .LOCK_CYC (20),
    .IDLE_CYC (30)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key1_p     (key1_p),
    .key2_p     (key2_p),
    .key3_p     (key3_p),
    .ok_p       (ok_p),
    .result     (result),
    .result_vld (result_vld),
    .digit_cnt  (digit_cnt),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k = 1..3 for a digit, 0 for ok
  task automatic press(input int k);
    key1_p = (k == 1);
    key2_p = (k == 2);
    key3_p = (k == 3);
    ok_p   = (k == 0);
    tick();
    key1_p = 1'b0; key2_p = 1'b0; key3_p = 1'b0; ok_p = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    total++; if (result !== 2'b00) begin bad++; $display("FAIL reset_result: got %b exp 00", result); end
    total++; if (result_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b exp 0", result_vld); end
    total++; if (digit_cnt !== 3'd0) begin bad++; $display("FAIL reset_digit_cnt: got %0d exp 0", digit_cnt); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b exp 0", locked); end
    press(1); press(2);
    total++; if (digit_cnt !== 3'd2) begin bad++; $display("FAIL mid_entry_cnt: got %0d exp 2", digit_cnt); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (digit_cnt !== 3'd0 || result !== 2'b00) begin bad++; $display("FAIL reset_abort_entry: got cnt=%0d res=%b exp cnt=0 res=00", digit_cnt, result); end
    press(3);
    total++; if (digit_cnt !== 3'd1 || result !== 2'b01) begin bad++; $display("FAIL first_cycle_accept: got cnt=%0d res=%b exp cnt=1 res=01", digit_cnt, result); end
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_pass();
    press(1); press(2); press(3); press(1);
    total++; if (digit_cnt !== 3'd4 || result !== 2'b01) begin bad++; $display("FAIL pass_entry: got cnt=%0d res=%b exp cnt=4 res=01", digit_cnt, result); end
    press(0);
    total++; if (result_vld !== 1'b0 || result !== 2'b01) begin bad++; $display("FAIL pass_check_cycle: got vld=%b res=%b exp vld=0 res=01", result_vld, result); end
    tick();
    total++; if (result_vld !== 1'b1 || result !== 2'b10) begin bad++; $display("FAIL pass_result: got vld=%b res=%b exp vld=1 res=10", result_vld, result); end
    total++; if (digit_cnt !== 3'd4) begin bad++; $display("FAIL pass_digit_cnt: got %0d exp 4", digit_cnt); end
    total++; if (dut.fail_cnt !== 2'd0) begin bad++; $display("FAIL pass_fail_cnt: got %0d exp 0", dut.fail_cnt); end
    press(0);
    total++; if (result_vld !== 1'b0 || result !== 2'b10) begin bad++; $display("FAIL pass_ok_ignored: got vld=%b res=%b exp vld=0 res=10", result_vld, result); end
  endtask

  task automatic test_lockout();
    int n;
    for (int a = 0; a < 3; a++) begin
      press(1); press(2); press(3); press(2); press(0); tick();
      total++; if (result !== 2'b11 || result_vld !== 1'b1) begin bad++; $display("FAIL wrong_code_%0d: got res=%b vld=%b exp res=11 vld=1", a, result, result_vld); end
      total++; if (dut.fail_cnt !== 2'(a + 1)) begin bad++; $display("FAIL fail_cnt_%0d: got %0d exp %0d", a, dut.fail_cnt, a + 1); end
    end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL locked_in_fail: got %b exp 0", locked); end
    tick();
    total++; if (locked !== 1'b1 || result !== 2'b11) begin bad++; $display("FAIL lockout_enter: got locked=%b res=%b exp locked=1 res=11", locked, result); end
    n = 0;
    while (locked === 1'b1 && n < 100) begin
      n++;
      key1_p = (n == 5);
      tick();
      key1_p = 1'b0;
    end
    total++; if (n !== 20) begin bad++; $display("FAIL lockout_len: got %0d exp 20", n); end
    total++; if (result !== 2'b00 || digit_cnt !== 3'd0) begin bad++; $display("FAIL lockout_exit: got res=%b cnt=%0d exp res=00 cnt=0", result, digit_cnt); end
    total++; if (dut.fail_cnt !== 2'd0) begin bad++; $display("FAIL lockout_fail_clr: got %0d exp 0", dut.fail_cnt); end
  endtask

  task automatic test_overflow();
    press(1); press(2); press(3); press(1); press(1);
    total++; if (digit_cnt !== 3'd5) begin bad++; $display("FAIL ovf_digit_cnt: got %0d exp 5", digit_cnt); end
    press(0); tick();
    total++; if (result !== 2'b11 || dut.fail_cnt !== 2'd1) begin bad++; $display("FAIL ovf_result: got res=%b fc=%0d exp res=11 fc=1", result, dut.fail_cnt); end
    press(1); press(2); press(0); tick();
    total++; if (result !== 2'b11 || dut.fail_cnt !== 2'd2) begin bad++; $display("FAIL short_result: got res=%b fc=%0d exp res=11 fc=2", result, dut.fail_cnt); end
    press(1); press(2); press(3); press(1); press(0); tick();
    total++; if (result !== 2'b10 || dut.fail_cnt !== 2'd0) begin bad++; $display("FAIL recover_pass: got res=%b fc=%0d exp res=10 fc=0", result, dut.fail_cnt); end
  endtask

  task automatic test_multi();
    press(1); press(2);
    key1_p = 1'b1; key2_p = 1'b1; tick(); key1_p = 1'b0; key2_p = 1'b0;
    total++; if (digit_cnt !== 3'd2 || result !== 2'b01) begin bad++; $display("FAIL multi_keys: got cnt=%0d res=%b exp cnt=2 res=01", digit_cnt, result); end
    key3_p = 1'b1; ok_p = 1'b1; tick(); key3_p = 1'b0; ok_p = 1'b0;
    tick();
    total++; if (digit_cnt !== 3'd2 || result !== 2'b01) begin bad++; $display("FAIL multi_key_ok: got cnt=%0d res=%b exp cnt=2 res=01", digit_cnt, result); end
    press(3); press(1); press(0); tick();
    total++; if (result !== 2'b10 || result_vld !== 1'b1) begin bad++; $display("FAIL multi_then_pass: got res=%b vld=%b exp res=10 vld=1", result, result_vld); end
  endtask

  task automatic test_timeout();
    press(2); press(2); press(2); press(2); press(0); tick();
    total++; if (result !== 2'b11 || dut.fail_cnt !== 2'd1) begin bad++; $display("FAIL to_prefail: got res=%b fc=%0d exp res=11 fc=1", result, dut.fail_cnt); end
    press(1); press(2);
    repeat (29) tick();
    total++; if (result !== 2'b01 || digit_cnt !== 3'd2) begin bad++; $display("FAIL to_before: got res=%b cnt=%0d exp res=01 cnt=2", result, digit_cnt); end
    tick();
    total++; if (result !== 2'b00 || digit_cnt !== 3'd0) begin bad++; $display("FAIL to_expired: got res=%b cnt=%0d exp res=00 cnt=0", result, digit_cnt); end
    total++; if (dut.fail_cnt !== 2'd1) begin bad++; $display("FAIL to_fail_kept: got %0d exp 1", dut.fail_cnt); end
  endtask

  task automatic test_lockout_reset();
    for (int a = 0; a < 2; a++) begin
      press(2); press(2); press(2); press(2); press(0); tick();
    end
    total++; if (result !== 2'b11 || dut.fail_cnt !== 2'd3) begin bad++; $display("FAIL lr_third_fail: got res=%b fc=%0d exp res=11 fc=3", result, dut.fail_cnt); end
    tick(); repeat (3) tick();
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lr_locked: got %b exp 1", locked); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (locked !== 1'b0 || result !== 2'b00 || dut.fail_cnt !== 2'd0) begin bad++; $display("FAIL lr_after_rst: got locked=%b res=%b fc=%0d exp 0/00/0", locked, result, dut.fail_cnt); end
    press(1); press(2); press(3); press(1); press(0); tick();
    total++; if (result !== 2'b10 || result_vld !== 1'b1) begin bad++; $display("FAIL lr_pass: got res=%b vld=%b exp res=10 vld=1", result, result_vld); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_lockout();
    test_overflow();
    test_multi();
    test_timeout();
    test_lockout_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got sim time limit exp bench completion");
    $fatal(1);
  end

endmodule
